// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl
// Description : Decode-stage hazard and forwarding controller. Keeps a
//               two-entry shadow (EX slot, MEM slot) of destination-register
//               info for in-flight instructions. It detects load-use hazards
//               and precomputes EX->EX / MEM->EX forwarding selects for the
//               instruction entering ID/EX. It also counts bubble cycles.
// Ports       :
//   clk, rst (async, active-low)
//   id_*        decoded fields of the instruction currently in ID
//   flush       squash ID instruction (taken branch/jump resolved in EX)
//   mem_busy    data memory not ready; freezes the whole pipe
//   stall       hold PC and IF/ID (load-use)
//   nop         insert bubble into ID/EX
//   Stall       global freeze to all pipeline registers
//   line{1,2}_EXEX / line{1,2}_MEMEX   forwarding selects for operand 1/2
//   stall_cnt   saturating count of non-frozen cycles with nop asserted
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs_sel,
  input  logic             id_rs_used,
  input  logic [2:0]       id_rt_sel,
  input  logic             id_rt_used,
  input  logic [2:0]       id_wr_sel,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             stall,
  output logic             nop,
  output logic             Stall,
  output logic             line1_EXEX,
  output logic             line2_EXEX,
  output logic             line1_MEMEX,
  output logic             line2_MEMEX,
  output logic [CNT_W-1:0] stall_cnt
);

  // Shadow slots: valid, destination register, writes-regfile, is-load
  logic             ex_v_q,  ex_v_d;
  logic [2:0]       ex_wr_q, ex_wr_d;
  logic             ex_rw_q, ex_rw_d;
  logic             ex_ld_q, ex_ld_d;
  logic             mem_v_q,  mem_v_d;
  logic [2:0]       mem_wr_q, mem_wr_d;
  logic             mem_rw_q, mem_rw_d;
  logic             mem_ld_q, mem_ld_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic lu, fwd_en, ex_fwd_rs, ex_fwd_rt;

  always_comb begin
    // R0 is writable, so every register index takes part in matching
    hit_ex_rs  = ex_v_q  & ex_rw_q  & id_valid & id_rs_used & (ex_wr_q  == id_rs_sel);
    hit_ex_rt  = ex_v_q  & ex_rw_q  & id_valid & id_rt_used & (ex_wr_q  == id_rt_sel);
    hit_mem_rs = mem_v_q & mem_rw_q & id_valid & id_rs_used & (mem_wr_q == id_rs_sel);
    hit_mem_rt = mem_v_q & mem_rw_q & id_valid & id_rt_used & (mem_wr_q == id_rt_sel);

    lu     = (hit_ex_rs | hit_ex_rt) & ex_ld_q;
    fwd_en = ~lu & ~flush;

    stall = lu & ~flush;
    nop   = flush | lu;
    Stall = mem_busy;

    // The EX producer is newer than the MEM producer, so it takes precedence
    ex_fwd_rs   = hit_ex_rs & ~ex_ld_q;
    ex_fwd_rt   = hit_ex_rt & ~ex_ld_q;
    line1_EXEX  = fwd_en & ex_fwd_rs;
    line2_EXEX  = fwd_en & ex_fwd_rt;
    line1_MEMEX = fwd_en & hit_mem_rs & ~ex_fwd_rs;
    line2_MEMEX = fwd_en & hit_mem_rt & ~ex_fwd_rt;

    // Default: hold everything (covers the mem_busy freeze)
    ex_v_d   = ex_v_q;
    ex_wr_d  = ex_wr_q;
    ex_rw_d  = ex_rw_q;
    ex_ld_d  = ex_ld_q;
    mem_v_d  = mem_v_q;
    mem_wr_d = mem_wr_q;
    mem_rw_d = mem_rw_q;
    mem_ld_d = mem_ld_q;
    cnt_d    = cnt_q;

    if (!mem_busy) begin
      mem_v_d  = ex_v_q;
      mem_wr_d = ex_wr_q;
      mem_rw_d = ex_rw_q;
      mem_ld_d = ex_ld_q;
      if (nop || !id_valid) begin
        ex_v_d  = 1'b0;
        ex_wr_d = 3'd0;
        ex_rw_d = 1'b0;
        ex_ld_d = 1'b0;
      end else begin
        ex_v_d  = 1'b1;
        ex_wr_d = id_wr_sel;
        ex_rw_d = id_reg_write;
        ex_ld_d = id_mem_read;
      end
      if (nop && !(&cnt_q)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v_q   <= 1'b0;
      ex_wr_q  <= 3'd0;
      ex_rw_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_wr_q <= 3'd0;
      mem_rw_q <= 1'b0;
      mem_ld_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_wr_q  <= ex_wr_d;
      ex_rw_q  <= ex_rw_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_wr_q <= mem_wr_d;
      mem_rw_q <= mem_rw_d;
      mem_ld_q <= mem_ld_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_ctrl
// Description : Directed self-checking bench for id_hazard_ctrl. Expected
//               outputs are queued as each step is driven and popped when
//               the outputs are sampled on the falling clock edge. A second
//               instance with a 3-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

  typedef struct {
    string      tag;
    logic [6:0] flags;   // {stall, nop, Stall, l1e, l2e, l1m, l2m}
    logic [15:0] cnt;
    logic [2:0] cnt_s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0, mem_busy = 1'b0;
  logic [2:0] id_rs_sel = 3'd0, id_rt_sel = 3'd0, id_wr_sel = 3'd0;

  logic stall, nop, Stall, line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX;
  logic [15:0] stall_cnt;
  logic s_stall, s_nop, s_Stall, s_l1e, s_l2e, s_l1m, s_l2m;
  logic [2:0] s_cnt;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_sel(id_wr_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_busy(mem_busy),
    .stall(stall), .nop(nop), .Stall(Stall),
    .line1_EXEX(line1_EXEX), .line2_EXEX(line2_EXEX),
    .line1_MEMEX(line1_MEMEX), .line2_MEMEX(line2_MEMEX),
    .stall_cnt(stall_cnt)
  );

  id_hazard_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_sel(id_wr_sel), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_busy(mem_busy),
    .stall(s_stall), .nop(s_nop), .Stall(s_Stall),
    .line1_EXEX(s_l1e), .line2_EXEX(s_l2e),
    .line1_MEMEX(s_l1m), .line2_MEMEX(s_l2m),
    .stall_cnt(s_cnt)
  );

  // Drive the ID instruction fields
  task automatic instr(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu,
                       input logic [2:0] wr, input logic rw, input logic ld);
    id_valid = v; id_rs_sel = rs; id_rs_used = rsu;
    id_rt_sel = rt; id_rt_used = rtu;
    id_wr_sel = wr; id_reg_write = rw; id_mem_read = ld;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] flags,
                            input int cnt);
    exp_t e;
    e.tag   = tag;
    e.flags = flags;
    e.cnt   = 16'(cnt);
    e.cnt_s = (cnt > 7) ? 3'd7 : 3'(cnt);
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    logic [6:0] obs;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries required 1");
      return;
    end
    e   = sb.pop_front();
    obs = {stall, nop, Stall, line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX};
    checks++;
    assert (obs === e.flags) else begin
      errors++;
      $error("FAIL %s flags{stall,nop,Stall,l1e,l2e,l1m,l2m}: observed %b expected %b",
             e.tag, obs, e.flags);
    end
    checks++;
    assert (stall_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s stall_cnt: observed %h expected %h", e.tag, stall_cnt, e.cnt);
    end
    checks++;
    assert (s_cnt === e.cnt_s) else begin
      errors++;
      $error("FAIL %s stall_cnt_sat3: observed %h expected %h", e.tag, s_cnt, e.cnt_s);
    end
  endtask

  // Sample on the falling edge, then advance past the next rising edge
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted from time 0, released while clock is low
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    instr(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_idle", 7'b0000000, 0); cycle();

    // ALU chain: ADD r3; consumer rs=r3 (EX fwd); third reads rt=r3 (MEM fwd)
    instr(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0);
    expect_out("alu_add_r3", 7'b0000000, 0); cycle();
    instr(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0);
    expect_out("alu_exex_rs", 7'b0001000, 0); cycle();
    instr(1, 3'd6, 1, 3'd3, 1, 3'd6, 1, 0);
    expect_out("alu_memex_rt", 7'b0000001, 0); cycle();

    // Load-use: LD r2, consumer rs=r2 stalls one cycle then MEM-forwards
    instr(1, 3'd7, 1, 3'd0, 0, 3'd2, 1, 1);
    expect_out("ld_r2", 7'b0000000, 0); cycle();
    instr(1, 3'd2, 1, 3'd0, 0, 3'd5, 1, 0);
    expect_out("lu_stall", 7'b1100000, 0); cycle();
    expect_out("lu_retry_memex", 7'b0000010, 1); cycle();

    // Double producer: EX and MEM both write r5
    instr(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0);
    expect_out("dbl_prod2", 7'b0000000, 1); cycle();
    instr(1, 3'd5, 1, 3'd5, 1, 3'd1, 0, 0);
    expect_out("dbl_exex_both", 7'b0001100, 1); cycle();

    // Non-writing producer in EX must not match; then LD into R0
    instr(1, 3'd1, 1, 3'd0, 0, 3'd0, 1, 1);
    expect_out("no_rw_no_fwd", 7'b0000000, 1); cycle();

    // Freeze during load-use on R0 (rt)
    instr(1, 3'd4, 0, 3'd0, 1, 3'd3, 1, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("freeze_lu", 7'b1110000, 1); cycle();
    end
    mem_busy = 1'b0;
    expect_out("unfreeze_lu", 7'b1100000, 1); cycle();
    expect_out("r0_memex_rt", 7'b0000001, 2); cycle();

    // Flush together with load-use
    instr(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1);
    expect_out("ld_r4", 7'b0000000, 2); cycle();
    instr(1, 3'd4, 1, 3'd3, 1, 3'd7, 1, 0);
    flush = 1'b1;
    expect_out("flush_lu", 7'b0100000, 2); cycle();
    flush = 1'b0;
    instr(1, 3'd7, 1, 3'd4, 1, 3'd0, 0, 0);
    expect_out("post_flush_ex_empty", 7'b0000001, 3); cycle();

    // Asynchronous reset in the middle of a load-use hazard
    instr(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1);
    expect_out("ld_r6", 7'b0000000, 3); cycle();
    instr(1, 3'd6, 1, 3'd0, 0, 3'd2, 1, 0);
    expect_out("pre_reset_lu", 7'b1100000, 3);
    @(negedge clk);
    sample();
    #1;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 7'b0000000, 0);
    sample();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    instr(1, 3'd6, 1, 3'd6, 1, 3'd1, 1, 0);
    expect_out("post_reset_no_fwd", 7'b0000000, 0); cycle();

    // Run flush bubbles past the small counter's all-ones value
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_out("bubble_sat", 7'b0100000, k); cycle();
    end
    // Frozen edge with nop=1 must not advance the counter
    mem_busy = 1'b1;
    expect_out("bubble_frozen", 7'b0110000, 10); cycle();
    expect_out("bubble_frozen_hold", 7'b0110000, 10); cycle();
    mem_busy = 1'b0;
    flush = 1'b0;
    expect_out("idle_final", 7'b0000000, 10); cycle();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Decode-stage hazard and forwarding controller. It sits directly upstream of the ID/EX pipeline register and drives that register's stall, nop, Stall and four forwarding-select inputs.
- It keeps a two-entry shadow of the destination-register info for the instructions now in EX and MEM. From this it detects load-use hazards and precomputes EX->EX and MEM->EX forwarding selects, which are registered alongside the decoded instruction.
- It also counts bubble cycles for performance analysis.

Parameters:
- CNT_W, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_sel  in  3  first source register of ID instruction
- id_rs_used  in  1  ID instruction reads rs
- id_rt_sel  in  3  second source register of ID instruction
- id_rt_used  in  1  ID instruction reads rt
- id_wr_sel  in  3  destination register of ID instruction
- id_reg_write  in  1  ID instruction writes register file
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  taken branch/jump resolved in EX; squash ID instruction
- mem_busy  in  1  data memory not ready; freeze whole pipe
- stall  out  1  hold PC and IF/ID (load-use)
- nop  out  1  insert bubble into ID/EX
- Stall  out  1  global freeze to all pipeline registers
- line1_EXEX  out  1  forward EX/MEM result to operand 1
- line2_EXEX  out  1  forward EX/MEM result to operand 2
- line1_MEMEX  out  1  forward MEM/WB result to operand 1
- line2_MEMEX  out  1  forward MEM/WB result to operand 2
- stall_cnt  out  CNT_W  cycles in which nop was asserted, saturating

Behaviour:
- State
  - EX slot and MEM slot, each holding {v, wr[2:0], rw, ld}.
  - stall_cnt.
  - Reset (rst low, async) clears all slot fields and stall_cnt to 0. With empty slots, stall/nop/line* are 0 unless flush is high; Stall follows mem_busy.
- Matching
  - Per slot S: hitS_rs = S.v & S.rw & id_valid & id_rs_used & (S.wr == id_rs_sel). hitS_rt is the same using rt.
  - All 8 registers are matched, including R0, because R0 is writable.
- Load-use
  - lu = hitEX_rs&EX.ld | hitEX_rt&EX.ld.
  - stall = lu & ~flush.
- Outputs (combinational from slots and ID inputs)
  - nop = flush | lu.
  - Stall = mem_busy.
- Forwarding (only when ~lu & ~flush; otherwise all four are 0)
  - line1_EXEX = hitEX_rs & ~EX.ld.
  - line1_MEMEX = hitMEM_rs & ~line1_EXEX, so the newer producer wins.
  - line2_* are the same using rt.
- Slot update (rising clk)
  - Priority: mem_busy > flush > lu > normal.
  - mem_busy=1: both slots and stall_cnt hold, regardless of flush/lu.
  - Otherwise MEM slot <= EX slot.
  - Otherwise EX slot <= (nop | ~id_valid) ? empty : {1, id_wr_sel, id_reg_write, id_mem_read}.
- Latency
  - A load-use stall lasts exactly 1 cycle. On the next cycle the load sits in MEM, the consumer retries, lu=0, and line*_MEMEX=1.
  - Back-to-back dependent ALU ops see 0 stall cycles.
- stall_cnt
  - Increments by 1 on each non-frozen edge where nop=1.
  - Saturates at all-ones and never wraps.
- Flush during lu: flush wins; stall=0, nop=1.
- Reset mid-operation: slots are cleared immediately. In-flight hazards are forgotten, and the first post-reset instruction sees no forwarding.

Test Plan:
- ALU chain: ADD r3<- ; next ID reads rs=r3, rs_used=1 -> line1_EXEX=1, stall=0, nop=0. One cycle later a third instruction reads rt=r3 -> line2_MEMEX=1.
- Load-use: LD r2 in EX, ID reads rs=r2 -> stall=1, nop=1 for exactly 1 cycle. Next cycle: stall=0, line1_MEMEX=1, stall_cnt=1.
- Double producer: EX and MEM both write r5, ID reads r5 on both operands -> line1_EXEX=line2_EXEX=1, both MEMEX=0.
- Freeze: assert mem_busy for 3 cycles during a load-use -> Stall=1, slots and stall_cnt unchanged; the hazard resolves 1 cycle after mem_busy drops.
- Flush + lu in the same cycle -> nop=1, stall=0, all line*=0; EX slot becomes empty next edge.
- Reset: assert rst=0 asynchronously mid-hazard -> stall=nop=0 and stall_cnt=0 immediately, no clock edge needed. Separately, force stall_cnt to 0xFFFF with a further bubble -> it stays 0xFFFF.
